// File: rtl/fetch_stage.sv
// Instruction-fetch control stage wrapped around the external PC register.
// Issues one instruction-memory read at a time, turns each response into a
// {pc, instr} packet for decode, produces the next-PC/load strobe and handles
// execute redirects by flushing the packet and discarding in-flight data.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_load_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_read_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_resp_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic        req_active_reg, req_active_next;
    logic [31:0] addr_reg, addr_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic [31:0] out_instr_reg, out_instr_next;

    logic redirect_take;
    logic resp_take;
    logic resp_fetch;
    logic drain;
    logic issue;

    // Redirects only count once the stage has left IDLE.
    assign redirect_take = redirect_i && (state_reg != ST_IDLE);
    // Any response to an outstanding request completes it, whatever the state.
    assign resp_take     = req_active_reg && imem_resp_i;
    // Only a FETCH-state response not hit by a redirect delivers a packet.
    assign resp_fetch    = resp_take && (state_reg == ST_FETCH) && !redirect_take;
    assign drain         = out_valid_reg && if_ready_i;
    // A redirect cycle does not issue: pc_i still holds the wrong-path PC.
    assign issue         = (state_reg == ST_FETCH) && !req_active_reg &&
                           (!out_valid_reg || if_ready_i) && !redirect_take;

    // Next-PC and load strobe; a redirect overrides the sequential +4 load.
    always_comb begin
        pc_load_o = 1'b0;
        pc_next_o = pc_i + 32'd4;
        if (redirect_take) begin
            pc_load_o = 1'b1;
            pc_next_o = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (resp_fetch) begin
            pc_load_o = 1'b1;
            pc_next_o = addr_reg + 32'd4;
        end
    end

    // Control state: DISCARD waits out a request made on the wrong path.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_take && req_active_reg && !imem_resp_i) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (resp_take) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request tracking: address latched at issue and held until the response.
    always_comb begin
        req_active_next = req_active_reg;
        addr_next       = addr_reg;
        if (resp_take) begin
            req_active_next = 1'b0;
        end else if (issue) begin
            req_active_next = 1'b1;
            addr_next       = pc_i;
        end
    end

    // Packet buffer: flush beats refill, refill beats drain.
    always_comb begin
        out_valid_next = out_valid_reg;
        out_pc_next    = out_pc_reg;
        out_instr_next = out_instr_reg;
        if (redirect_take) begin
            out_valid_next = 1'b0;
            out_instr_next = NOP_INSTR;
        end else if (resp_fetch) begin
            out_valid_next = 1'b1;
            out_pc_next    = addr_reg;
            out_instr_next = imem_rdata_i;
        end else if (drain) begin
            out_valid_next = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            req_active_reg <= 1'b0;
            addr_reg       <= RESET_PC;
            out_valid_reg  <= 1'b0;
            out_pc_reg     <= RESET_PC;
            out_instr_reg  <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            req_active_reg <= req_active_next;
            addr_reg       <= addr_next;
            out_valid_reg  <= out_valid_next;
            out_pc_reg     <= out_pc_next;
            out_instr_reg  <= out_instr_next;
        end
    end

    assign imem_read_o = req_active_reg;
    assign imem_addr_o = addr_reg;
    assign if_valid_o  = out_valid_reg;
    assign if_pc_o     = out_pc_reg;
    assign if_instr_o  = out_instr_reg;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch control stage that sits around the PC register.
- Consumes the current PC and computes next-PC plus the load strobe that feeds back into the PC register.
- Runs the instruction-memory read handshake and presents one {pc, instr} fetch packet at a time to decode over a valid/ready interface.
- Handles redirects from execute (branch/jump): the PC is updated and wrong-path fetches are discarded.

Parameters:
- RESET_PC, 32'h40000000, value reported on if_pc_o while in reset; matches the PC register reset value.
- NOP_INSTR, 32'h00000013, value of if_instr_o while in reset and after a flush.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- pc_i  in  32  current PC from the PC register.
- pc_next_o  out  32  next-PC value to the PC register input.
- pc_load_o  out  1  load strobe to the PC register.
- redirect_i  in  1  one-cycle redirect pulse from execute.
- redirect_pc_i  in  32  redirect target.
- imem_read_o  out  1  instruction-memory read request.
- imem_addr_o  out  32  read address.
- imem_resp_i  in  1  memory response valid.
- imem_rdata_i  in  32  instruction word, valid when imem_resp_i=1.
- if_valid_o  out  1  fetch packet valid.
- if_ready_i  in  1  decode accepts the packet.
- if_pc_o  out  32  PC of the packet.
- if_instr_o  out  32  instruction of the packet.

Behaviour:
- States: IDLE, FETCH, DISCARD.
- Registers: state, req_active, out_valid, out_pc, out_instr.
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, req_active=0, out_valid=0, out_pc=RESET_PC, out_instr=NOP_INSTR.
  - imem_read_o=0, pc_load_o=0, if_valid_o=0.
- IDLE -> FETCH unconditionally on the first edge after reset deasserts. No request is issued in IDLE.
- imem_read_o = req_active. imem_addr_o = the PC latched at issue; it is held stable while req_active=1.
- Issue (FETCH only): when req_active=0 and (out_valid=0 or if_ready_i=1), set req_active=1 and latch the address from pc_i.
  - Once issued, the request is held until imem_resp_i=1 and is never withdrawn.
- Response in FETCH (req_active=1 and imem_resp_i=1):
  - Capture out_pc=address and out_instr=imem_rdata_i, and set out_valid=1.
  - Clear req_active.
  - Same cycle: pc_load_o=1, pc_next_o=address+4 (modulo 2^32; 32'hFFFFFFFC wraps to 0).
- Decode handshake:
  - A packet transfers on if_valid_o && if_ready_i; out_valid clears unless refilled the same edge.
  - Capture and drain on the same edge are both legal: the refill wins and out_valid stays 1.
  - Packet fields are stable while if_valid_o=1 and if_ready_i=0.
- Redirect (highest priority, any state except IDLE):
  - pc_load_o=1 and pc_next_o={redirect_pc_i[31:2],2'b00}; this overrides any +4 load in the same cycle.
  - Flush: out_valid=0 and out_instr=NOP_INSTR.
  - If req_active=1 and imem_resp_i=0: go to DISCARD.
  - If imem_resp_i=1 the same cycle: drop the data, clear req_active, stay in or go to FETCH.
  - If no request is outstanding: stay in FETCH.
- DISCARD:
  - The request stays asserted at the old address until imem_resp_i; the response data is dropped and no +4 load occurs.
  - Then go to FETCH; the next issue uses the redirected pc_i.
  - A further redirect while in DISCARD updates the PC again and the state remains DISCARD.
- Redirect in IDLE is ignored: pc_load_o=0.
- pc_load_o is 0 in all cases not listed above. pc_next_o is don't-care when pc_load_o=0, and is driven pc_i+4.
- Latency: a response with if_ready_i=1 gives one instruction per 2 cycles (issue, then respond) when memory responds in the issue cycle.
- Reset asserted mid-request: the request is abandoned; any late imem_resp_i after reset is ignored because req_active=0.

Test Plan:
- Reset release, pc_i=0x40000000, memory responds in 1 cycle with 0x00A00093, if_ready_i=1 -> imem_addr_o=0x40000000; pc_load_o pulses with pc_next_o=0x40000004; if_valid_o=1, if_pc_o=0x40000000, if_instr_o=0x00A00093.
- if_ready_i=0 for 5 cycles with a packet valid -> no new imem_read_o issue; packet fields constant; after ready=1, exactly one transfer and then the next issue at 0x40000004.
- Memory latency of 3 cycles -> imem_read_o and imem_addr_o held 3 cycles; exactly one pc_load_o pulse on the response cycle.
- Redirect to 0x40000102 while a request to 0x40000008 is outstanding -> pc_next_o=0x40000100; state DISCARD; the 0x40000008 response is dropped (if_valid_o stays 0); next fetch at 0x40000100.
- Redirect coinciding with a response and an occupied packet -> data dropped, packet flushed, pc_next_o is the redirect target (not +4).
- pc_i=0xFFFFFFFC response -> pc_next_o=0x00000000; rst_ni asserted mid-request -> all outputs at reset values immediately.
